// File: rtl/msdap_output_serializer.sv
// msdap_output_serializer
// Output stage of the MSDAP datapath. Buffers 40-bit left/right filter results
// in a small FIFO and shifts one word pair out per frame, MSB first, on
// outputL/outputR. outReady marks each WORD_W-cycle transmission window.
// Everything runs on sclk. The frame marker comes from the dclk domain and is
// synchronized here.
//
// Build option: define MSDAP_OSER_ZERO_FILL_EN to transmit an all-zero word
// pair when a frame arrives with the FIFO empty. Without it, an underflowing
// frame only raises the sticky underflow flag.

module msdap_output_serializer #(
  parameter int WORD_W      = 40,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     sclk,
  input  logic                     reset,
  input  logic                     frame,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W-1:0]        in_left,
  input  logic [WORD_W-1:0]        in_right,
  output logic                     outReady,
  output logic                     outputL,
  output logic                     outputR,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underflow,
  output logic                     frame_miss
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(WORD_W);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Frame synchronizer and edge detect
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_prev;
  logic                   frame_rise;

  // FIFO storage and bookkeeping
  logic [WORD_W-1:0] mem_l [DEPTH];
  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_next;

  // Serializer state
  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] sh_l;
  logic [WORD_W-1:0] sh_r;

  // Per-cycle control decisions
  logic              push;
  logic              pop;
  logic              start;
  logic              underflow_set;
  logic              miss_set;
  logic [WORD_W-1:0] load_l;
  logic [WORD_W-1:0] load_r;

  // Shift the asynchronous frame marker through the synchronizer and register its rising edge
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      sync_chain <= '0;
      sync_prev  <= 1'b0;
      frame_rise <= 1'b0;
    end else begin
      sync_chain[0] <= frame;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= sync_chain[i-1];
      end
      sync_prev  <= sync_chain[SYNC_STAGES-1];
      frame_rise <= sync_chain[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  // Decide push, pop, window start and flag events for this cycle
  always_comb begin
    push          = 1'b0;
    pop           = 1'b0;
    start         = 1'b0;
    underflow_set = 1'b0;
    miss_set      = 1'b0;
    if (frame_rise && (state == IDLE) && (fifo_level == LVL_ZERO)) begin
      underflow_set = 1'b1;
    end else begin
      underflow_set = 1'b0;
    end
    if (frame_rise && (state == SHIFT)) begin
      miss_set = 1'b1;
    end else begin
      miss_set = 1'b0;
    end
    if (flush) begin
      // Flush wins over both pop and push; nothing moves this cycle.
      push  = 1'b0;
      pop   = 1'b0;
      start = 1'b0;
    end else begin
      push = in_valid & in_ready;
      if (frame_rise && (state == IDLE)) begin
        if (fifo_level != LVL_ZERO) begin
          pop   = 1'b1;
          start = 1'b1;
        end else begin
          pop = 1'b0;
`ifdef MSDAP_OSER_ZERO_FILL_EN
          start = 1'b1;
`else
          start = 1'b0;
`endif
        end
      end else begin
        pop   = 1'b0;
        start = 1'b0;
      end
    end
  end

  // Select the word pair loaded into the shifters: FIFO head, or zeros on an underflow fill
  always_comb begin
    load_l = '0;
    load_r = '0;
    if (pop) begin
      load_l = mem_l[rd_ptr];
      load_r = mem_r[rd_ptr];
    end else begin
      load_l = '0;
      load_r = '0;
    end
  end

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + LVL_ONE;
      2'b01:   level_next = fifo_level - LVL_ONE;
      default: level_next = fifo_level;
    endcase
  end

  // FIFO word storage, written at the write pointer on every accepted push
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
    end else if (push) begin
      mem_l[wr_ptr] <= in_left;
      mem_r[wr_ptr] <= in_right;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_l[i] <= mem_l[i];
        mem_r[i] <= mem_r[i];
      end
    end
  end

  // FIFO pointers, level and the registered ready flag
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= LVL_ZERO;
      in_ready   <= 1'b1;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= LVL_ZERO;
      in_ready   <= 1'b1;
    end else begin
      // Pointers are PTR_W wide with DEPTH a power of two, so they wrap naturally.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        rd_ptr <= rd_ptr;
      end
      fifo_level <= level_next;
      in_ready   <= (level_next < LVL_FULL);
    end
  end

  // Serializer FSM: load a word pair on a frame, shift it out MSB first, then return to IDLE
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= CNT_ZERO;
      sh_l     <= '0;
      sh_r     <= '0;
      outReady <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      bit_cnt  <= CNT_ZERO;
      sh_l     <= '0;
      sh_r     <= '0;
      outReady <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SHIFT;
            bit_cnt  <= CNT_LAST;
            sh_l     <= load_l;
            sh_r     <= load_r;
            outReady <= 1'b1;
          end else begin
            state    <= IDLE;
            bit_cnt  <= CNT_ZERO;
            sh_l     <= '0;
            sh_r     <= '0;
            outReady <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt == CNT_ZERO) begin
            // Clearing the shifters keeps the serial pins low outside the window.
            state    <= IDLE;
            bit_cnt  <= CNT_ZERO;
            sh_l     <= '0;
            sh_r     <= '0;
            outReady <= 1'b0;
          end else begin
            state    <= SHIFT;
            bit_cnt  <= bit_cnt - CNT_ONE;
            sh_l     <= {sh_l[WORD_W-2:0], 1'b0};
            sh_r     <= {sh_r[WORD_W-2:0], 1'b0};
            outReady <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bit_cnt  <= CNT_ZERO;
          sh_l     <= '0;
          sh_r     <= '0;
          outReady <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; only reset clears them, flush leaves them alone
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      underflow  <= 1'b0;
      frame_miss <= 1'b0;
    end else begin
      if (underflow_set) begin
        underflow <= 1'b1;
      end else begin
        underflow <= underflow;
      end
      if (miss_set) begin
        frame_miss <= 1'b1;
      end else begin
        frame_miss <= frame_miss;
      end
    end
  end

  // Serial pins are the shifter MSBs; the shifters hold zero whenever outReady is low
  assign outputL = sh_l[WORD_W-1];
  assign outputR = sh_r[WORD_W-1];

endmodule

// File: tb/tb_msdap_output_serializer.sv
// Directed bench for msdap_output_serializer (WORD_W=40, DEPTH=2, SYNC_STAGES=2).
// Expected words and latencies are hand-computed constants.
`timescale 1ns/1ps

module tb_msdap_output_serializer;

  localparam int W = 40;

  logic          sclk = 1'b0;
  logic          reset;
  logic          frame;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_left;
  logic [W-1:0]  in_right;
  logic          outReady;
  logic          outputL;
  logic          outputR;
  logic [1:0]    fifo_level;
  logic          underflow;
  logic          frame_miss;

  int n_tests = 0;
  int n_fail  = 0;

  msdap_output_serializer #(.WORD_W(W), .DEPTH(2), .SYNC_STAGES(2)) dut (
    .sclk       (sclk),
    .reset      (reset),
    .frame      (frame),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_left    (in_left),
    .in_right   (in_right),
    .outReady   (outReady),
    .outputL    (outputL),
    .outputR    (outputR),
    .fifo_level (fifo_level),
    .underflow  (underflow),
    .frame_miss (frame_miss)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    @(negedge sclk);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    @(posedge sclk);
    #1;
    in_valid = 1'b0;
  endtask

  // Raise frame for three cycles and wait (bounded) until outReady is seen at a negedge.
  // lat counts rising edges from the first one that samples frame high.
  task automatic start_frame(output int lat);
    lat = 0;
    @(negedge sclk);
    frame = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge sclk);
      @(negedge sclk);
      lat++;
      if (lat == 3) frame = 1'b0;
      if (outReady === 1'b1) break;
    end
    frame = 1'b0;
  endtask

  // Send a frame and capture the whole window. miss_at >= 0 raises a second
  // frame pulse that many bits into the window.
  task automatic frame_capture(input int miss_at, output int lat, output int win,
                               output logic [W-1:0] wl, output logic [W-1:0] wr);
    win = 0;
    wl  = '0;
    wr  = '0;
    start_frame(lat);
    while (outReady === 1'b1 && win < 60) begin
      wl = {wl[W-2:0], outputL};
      wr = {wr[W-2:0], outputR};
      if (win == miss_at) frame = 1'b1;
      if (miss_at >= 0 && win == miss_at + 3) frame = 1'b0;
      win++;
      @(posedge sclk);
      @(negedge sclk);
    end
    frame = 1'b0;
  endtask

  initial begin
    int lat;
    int win;
    logic [W-1:0] wl;
    logic [W-1:0] wr;

    reset    = 1'b1;
    frame    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    repeat (3) @(negedge sclk);

    // Reset state
    check("rst_outReady",   outReady,   1'b0);
    check("rst_outputL",    outputL,    1'b0);
    check("rst_outputR",    outputR,    1'b0);
    check("rst_level",      fifo_level, 2'd0);
    check("rst_in_ready",   in_ready,   1'b1);
    check("rst_underflow",  underflow,  1'b0);
    check("rst_frame_miss", frame_miss, 1'b0);
    reset = 1'b0;

    // Basic transfer: latency, window length and bit order
    push_pair(40'h80_0000_0001, 40'h00_0000_0001);
    @(negedge sclk);
    check("t1_level_after_push", fifo_level, 2'd1);
    frame_capture(-1, lat, win, wl, wr);
    check("t1_latency", lat, 4);
    check("t1_window",  win, 40);
    check("t1_left",    wl,  40'h80_0000_0001);
    check("t1_right",   wr,  40'h00_0000_0001);
    check("t1_level",   fifo_level, 2'd0);
    check("t1_underflow", underflow, 1'b0);

    // Full FIFO stalls the third push; words leave in push order
    push_pair(40'h12_3456_789A, 40'hFE_DCBA_9876);
    push_pair(40'hAA_5555_AAAA, 40'h01_0203_0405);
    @(negedge sclk);
    check("t2_level_full", fifo_level, 2'd2);
    check("t2_ready_full", in_ready,   1'b0);
    in_valid = 1'b1;
    in_left  = 40'hC3_0F0F_F0F0;
    in_right = 40'h7F_FFFF_FFFF;
    @(posedge sclk);
    @(negedge sclk);
    check("t2_stall_level", fifo_level, 2'd2);
    check("t2_stall_ready", in_ready,   1'b0);
    in_valid = 1'b0;
    frame_capture(-1, lat, win, wl, wr);
    check("t2_w0_left",  wl, 40'h12_3456_789A);
    check("t2_w0_right", wr, 40'hFE_DCBA_9876);
    check("t2_ready_after", in_ready,   1'b1);
    check("t2_level_after", fifo_level, 2'd1);
    push_pair(40'hC3_0F0F_F0F0, 40'h7F_FFFF_FFFF);
    @(negedge sclk);
    check("t2_level_refill", fifo_level, 2'd2);
    frame_capture(-1, lat, win, wl, wr);
    check("t2_w1_left",  wl, 40'hAA_5555_AAAA);
    check("t2_w1_right", wr, 40'h01_0203_0405);
    frame_capture(-1, lat, win, wl, wr);
    check("t2_w2_left",  wl, 40'hC3_0F0F_F0F0);
    check("t2_w2_right", wr, 40'h7F_FFFF_FFFF);
    check("t2_w2_window", win, 40);
    check("t2_level_empty", fifo_level, 2'd0);

    // Frame with an empty FIFO
    check("t3_underflow_before", underflow, 1'b0);
    frame_capture(-1, lat, win, wl, wr);
`ifdef MSDAP_OSER_ZERO_FILL_EN
    check("t3_zero_window", win, 40);
    check("t3_zero_left",   wl,  40'h0);
    check("t3_zero_right",  wr,  40'h0);
`else
    check("t3_no_window", win, 0);
`endif
    check("t3_underflow", underflow, 1'b1);
    check("t3_frame_miss", frame_miss, 1'b0);

    // Second frame 20 bits into a window
    push_pair(40'h9C_1234_5678, 40'h3A_CAFE_BABE);
    push_pair(40'h5A_A5A5_0FF0, 40'hE1_0000_0080);
    frame_capture(20, lat, win, wl, wr);
    check("t4_window",    win, 40);
    check("t4_left",      wl,  40'h9C_1234_5678);
    check("t4_right",     wr,  40'h3A_CAFE_BABE);
    check("t4_frame_miss", frame_miss, 1'b1);
    check("t4_level_mid", fifo_level, 2'd1);
    frame_capture(-1, lat, win, wl, wr);
    check("t4_next_left",  wl, 40'h5A_A5A5_0FF0);
    check("t4_next_right", wr, 40'hE1_0000_0080);

    // Flush 10 cycles into a window with one word still queued
    @(negedge sclk);
    reset = 1'b1;
    @(negedge sclk);
    reset = 1'b0;
    check("t5_underflow_cleared", underflow,  1'b0);
    check("t5_miss_cleared",      frame_miss, 1'b0);
    push_pair(40'hFF_0000_FFFF, 40'hF0_F0F0_F0F0);
    push_pair(40'h11_2233_4455, 40'h66_7788_99AA);
    start_frame(lat);
    check("t5_window_started", outReady, 1'b1);
    repeat (10) @(negedge sclk);
    flush = 1'b1;
    @(negedge sclk);
    flush = 1'b0;
    check("t5_flush_outReady", outReady,   1'b0);
    check("t5_flush_outputL",  outputL,    1'b0);
    check("t5_flush_outputR",  outputR,    1'b0);
    check("t5_flush_level",    fifo_level, 2'd0);
    check("t5_flush_ready",    in_ready,   1'b1);
    check("t5_flush_underflow", underflow, 1'b0);
    frame_capture(-1, lat, win, wl, wr);
`ifdef MSDAP_OSER_ZERO_FILL_EN
    check("t5_zero_window", win, 40);
    check("t5_zero_left",   wl,  40'h0);
`else
    check("t5_no_window", win, 0);
`endif
    check("t5_underflow", underflow, 1'b1);

    // Asynchronous reset in the middle of a window
    push_pair(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
    push_pair(40'h01_0000_0000, 40'h02_0000_0000);
    start_frame(lat);
    repeat (5) @(negedge sclk);
    check("t6_pre_outReady", outReady, 1'b1);
    check("t6_pre_outputL",  outputL,  1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_outReady",  outReady,   1'b0);
    check("t6_async_outputL",   outputL,    1'b0);
    check("t6_async_outputR",   outputR,    1'b0);
    check("t6_async_level",     fifo_level, 2'd0);
    check("t6_async_ready",     in_ready,   1'b1);
    check("t6_async_underflow", underflow,  1'b0);
    @(negedge sclk);
    reset = 1'b0;
    repeat (2) @(negedge sclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
